stsystem_tx_shifter: RTL and testbench

- Transmit framing and shift stage of the Serial Transmission System, clocked by txclk.
- Accepts a parallel data word through a valid/ready handshake and holds it in a one-deep buffer.
- Builds an asynchronous-serial frame: start bit, data LSB first, parity bit, stop bit.
- Shifts the frame out on txd one bit per txclk and signals frame completion on TXE with a one-cycle pulse. Downstream consumers use TXE as their frame-done event.

---
 rtl/stsystem_tx_shifter_if.sv | 12 +
 rtl/stsystem_tx_shifter.sv | 83 ++++++++
 tb/tb_stsystem_tx_shifter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stsystem_tx_shifter_if.sv
// Parallel-word handshake into the transmit shifter: source drives tx_data/tx_valid,
// the shifter answers with tx_ready.
interface stsystem_tx_shifter_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/stsystem_tx_shifter.sv
// Transmit framing/shift stage: one-deep holding buffer feeding a start/data/parity/stop
// serialiser on txd, one bit per txclk, with a one-cycle TXE pulse per completed frame.
module stsystem_tx_shifter #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 txclk,
  input  logic                 clr,
  stsystem_tx_shifter_if.slave tx,
  output logic                 txd,
  output logic                 busy,
  output logic                 TXE,
  output logic [3:0]           bit_cnt
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS + 3);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t               state;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_buf;
  // Bits still to go after the start bit: data LSB first, then parity, then stop.
  logic [DATA_BITS+1:0] shreg;

  logic frame_end;
  logic load;
  logic shifting;
  logic parity;

  assign tx.tx_ready = !hold_full;

  always_comb begin
    frame_end = (state == SHIFT) && (bit_cnt == LAST_BIT);
    load      = hold_full && ((state == IDLE) || frame_end);
    shifting  = (state == SHIFT) && (bit_cnt != 4'd0) && (bit_cnt < LAST_BIT);
    parity    = (^hold_buf) ^ PARITY_ODD;
  end

  always_ff @(posedge txclk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold_buf  <= '0;
      shreg     <= '1;
      txd       <= 1'b1;
      busy      <= 1'b0;
      TXE       <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      TXE <= frame_end;

      // Accept and load are mutually exclusive: accept needs an empty buffer, load a full one.
      if (tx.tx_valid && !hold_full) begin
        hold_buf  <= tx.tx_data;
        hold_full <= 1'b1;
      end

      if (load) begin
        hold_full <= 1'b0;
        shreg     <= {1'b1, parity, hold_buf};
        txd       <= 1'b0;
        bit_cnt   <= 4'd1;
        busy      <= 1'b1;
        state     <= SHIFT;
      end else if (shifting) begin
        txd     <= shreg[0];
        shreg   <= {1'b1, shreg[DATA_BITS+1:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end else begin
        // Idle, frame finished with nothing buffered, or an unreachable count.
        txd     <= 1'b1;
        busy    <= 1'b0;
        bit_cnt <= '0;
        state   <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_stsystem_tx_shifter.sv
// Bench for stsystem_tx_shifter: even- and odd-parity instances fed the same stimulus,
// checked every cycle against a frame-level model plus hand-computed waveforms.
module tb_stsystem_tx_shifter;

  localparam int DB = 8;
  localparam int L  = DB + 3;

  logic          txclk = 1'b0;
  logic          clr;
  logic          txd_e, busy_e, txe_e;
  logic          txd_o, busy_o, txe_o;
  logic [3:0]    cnt_e, cnt_o;

  int n_vec = 0;
  int n_err = 0;

  stsystem_tx_shifter_if #(.DATA_BITS(DB)) ife ();
  stsystem_tx_shifter_if #(.DATA_BITS(DB)) ifo ();

  assign ifo.tx_data  = ife.tx_data;
  assign ifo.tx_valid = ife.tx_valid;

  stsystem_tx_shifter #(.DATA_BITS(DB), .PARITY_ODD(1'b0)) dut_even (
    .txclk(txclk), .clr(clr), .tx(ife.slave),
    .txd(txd_e), .busy(busy_e), .TXE(txe_e), .bit_cnt(cnt_e)
  );

  stsystem_tx_shifter #(.DATA_BITS(DB), .PARITY_ODD(1'b1)) dut_odd (
    .txclk(txclk), .clr(clr), .tx(ifo.slave),
    .txd(txd_o), .busy(busy_o), .TXE(txe_o), .bit_cnt(cnt_o)
  );

  always #5 txclk = ~txclk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Whole frame as a bit vector, index 0 = start bit, transmitted in index order.
  function automatic logic [L-1:0] mkframe(input logic [DB-1:0] w, input bit odd);
    logic par;
    par = (($countones(w) % 2) != 0) ^ odd;
    return {1'b1, par, w, 1'b0};
  endfunction

  // Model: pos = 1-based index of the frame bit on the line (0 = idle), hq = holding buffer.
  int             pos;
  logic [DB-1:0]  hq[$];
  logic [L-1:0]   fr_e, fr_o;
  logic           m_txe;
  logic [DB-1:0]  rx;
  logic [DB-1:0]  rxq[$];

  initial begin
    bit            acc;
    logic [DB-1:0] din;
    logic [DB-1:0] w;
    pos   = 0;
    m_txe = 1'b0;
    fr_e  = '1;
    fr_o  = '1;
    rx    = '0;
    forever begin
      @(posedge txclk);
      if (!clr) begin
        pos   = 0;
        m_txe = 1'b0;
        hq.delete();
      end else begin
        acc   = ife.tx_valid && (hq.size() == 0);
        din   = ife.tx_data;
        m_txe = (pos == L);
        if (pos == 0 || pos == L) begin
          if (hq.size() != 0) begin
            w    = hq.pop_front();
            fr_e = mkframe(w, 1'b0);
            fr_o = mkframe(w, 1'b1);
            pos  = 1;
          end else begin
            pos = 0;
          end
        end else begin
          pos++;
        end
        if (acc) hq.push_back(din);
      end
      #1;
      chk("txd_even",  txd_e, (pos == 0) ? 1'b1 : fr_e[pos-1]);
      chk("txd_odd",   txd_o, (pos == 0) ? 1'b1 : fr_o[pos-1]);
      chk("busy",      busy_e, pos != 0);
      chk("busy_odd",  busy_o, pos != 0);
      chk("TXE",       txe_e, m_txe);
      chk("TXE_odd",   txe_o, m_txe);
      chk("bit_cnt",   cnt_e, 16'(pos));
      chk("bit_cnt_o", cnt_o, 16'(pos));
      chk("tx_ready",  ife.tx_ready, hq.size() == 0);
      chk("tx_ready_o", ifo.tx_ready, hq.size() == 0);
      // Deserialise the even instance's line to check word order end to end.
      if (busy_e && cnt_e >= 4'd2 && cnt_e <= 4'(DB + 1)) rx[cnt_e - 4'd2] = txd_e;
      if (txe_e) rxq.push_back(rx);
    end
  end

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (!(busy_e == 1'b0 && ife.tx_ready == 1'b1 && txe_e == 1'b0) && c < 60) begin
      @(negedge txclk);
      c++;
    end
    chk(nm, 16'(c < 60), 16'd1);
  endtask

  task automatic send_words(input logic [DB-1:0] ws[$], input string nm);
    int idx;
    bit will;
    idx = 0;
    @(negedge txclk);
    ife.tx_valid = 1'b1;
    ife.tx_data  = ws[0];
    for (int c = 0; c < 200 && idx < ws.size(); c++) begin
      will = ife.tx_valid && ife.tx_ready;
      @(negedge txclk);
      if (will) begin
        idx++;
        if (idx < ws.size()) ife.tx_data = ws[idx];
        else                 ife.tx_valid = 1'b0;
      end
    end
    ife.tx_valid = 1'b0;
    chk(nm, 16'(idx), 16'(ws.size()));
  endtask

  bit a5_seq [1:11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

  initial begin
    logic [DB-1:0] ws[$];
    clr          = 1'b0;
    ife.tx_valid = 1'b0;
    ife.tx_data  = '0;

    // Reset held with junk on the handshake.
    for (int k = 0; k < 4; k++) begin
      @(negedge txclk);
      ife.tx_valid = 1'($urandom);
      ife.tx_data  = DB'($urandom);
      #2;
      chk("rst_txd", txd_e, 1'b1);
      chk("rst_busy", busy_e, 1'b0);
      chk("rst_TXE", txe_e, 1'b0);
      chk("rst_cnt", cnt_e, 4'd0);
      chk("rst_ready", ife.tx_ready, 1'b1);
    end
    @(negedge txclk);
    ife.tx_valid = 1'b0;
    clr          = 1'b1;
    repeat (2) @(negedge txclk);

    // Single frame 8'hA5.
    ife.tx_valid = 1'b1;
    ife.tx_data  = 8'hA5;
    @(negedge txclk);
    ife.tx_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge txclk);
      chk("a5_txd", txd_e, a5_seq[k]);
      chk("a5_TXE_low", txe_e, 1'b0);
      if (k == 10) chk("a5_parity_odd", txd_o, 1'b1);
    end
    @(negedge txclk);
    chk("a5_TXE", txe_e, 1'b1);
    chk("a5_busy_end", busy_e, 1'b0);
    chk("a5_txd_end", txd_e, 1'b1);
    wait_idle("a5_idle");

    // Parity of 8'h07: even instance sends 1, odd instance 0.
    @(negedge txclk);
    ife.tx_valid = 1'b1;
    ife.tx_data  = 8'h07;
    @(negedge txclk);
    ife.tx_valid = 1'b0;
    repeat (10) @(negedge txclk);
    chk("p07_even", txd_e, 1'b1);
    chk("p07_odd", txd_o, 1'b0);
    wait_idle("p07_idle");

    // Back-to-back 8'h3C then 8'hFF.
    rxq.delete();
    @(negedge txclk);
    ife.tx_valid = 1'b1;
    ife.tx_data  = 8'h3C;
    @(negedge txclk);
    ife.tx_data  = 8'hFF;
    for (int k = 1; k <= 23; k++) begin
      @(negedge txclk);
      if (k == 2) ife.tx_valid = 1'b0;
      if (k <= 22) chk("b2b_busy", busy_e, 1'b1);
      chk("b2b_TXE", txe_e, (k == 12) || (k == 23));
      if (k == 12) chk("b2b_start2", txd_e, 1'b0);
      if (k == 23) chk("b2b_busy_end", busy_e, 1'b0);
    end
    chk("b2b_count", 16'(rxq.size()), 16'd2);
    if (rxq.size() == 2) begin
      chk("b2b_w0", rxq[0], 8'h3C);
      chk("b2b_w1", rxq[1], 8'hFF);
    end

    // Back-pressure with three words offered continuously.
    rxq.delete();
    ws = '{8'h11, 8'h22, 8'h33};
    send_words(ws, "bp_accepts");
    wait_idle("bp_idle");
    chk("bp_count", 16'(rxq.size()), 16'd3);
    if (rxq.size() == 3) begin
      chk("bp_w0", rxq[0], 8'h11);
      chk("bp_w1", rxq[1], 8'h22);
      chk("bp_w2", rxq[2], 8'h33);
    end

    // Reset mid-frame with a word buffered.
    rxq.delete();
    @(negedge txclk);
    ife.tx_valid = 1'b1;
    ife.tx_data  = 8'h55;
    @(negedge txclk);
    ife.tx_data  = 8'h66;
    for (int k = 1; k < 20 && cnt_e != 4'd5; k++) begin
      @(negedge txclk);
      if (k == 2) ife.tx_valid = 1'b0;
    end
    ife.tx_valid = 1'b0;
    chk("mid_reached5", cnt_e, 4'd5);
    chk("mid_buffered", ife.tx_ready, 1'b0);
    clr = 1'b0;
    #1;
    chk("mid_txd", txd_e, 1'b1);
    chk("mid_busy", busy_e, 1'b0);
    chk("mid_cnt", cnt_e, 4'd0);
    chk("mid_ready", ife.tx_ready, 1'b1);
    repeat (2) @(negedge txclk);
    clr = 1'b1;
    repeat (20) @(negedge txclk);
    chk("mid_no_frame", 16'(rxq.size()), 16'd0);
    chk("mid_idle_txd", txd_e, 1'b1);
    ws = '{8'hAA};
    send_words(ws, "mid_resend");
    wait_idle("mid_idle");
    chk("mid_after_count", 16'(rxq.size()), 16'd1);
    if (rxq.size() == 1) chk("mid_after_w", rxq[0], 8'hAA);

    repeat (2) @(negedge txclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
